// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined dual-mode CORDIC (rotation/vectoring) with quadrant folding and valid/ready flow control
module cordic_pipe #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 16,
    parameter int STAGES  = 14,
    parameter int K_INIT  = 9949
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [PHASE_W-1:0]        in_phase,
    input  logic signed [DATA_W-1:0]  in_x,
    input  logic signed [DATA_W-1:0]  in_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_mode,
    output logic signed [DATA_W+1:0]  out_x,
    output logic signed [DATA_W+1:0]  out_y,
    output logic [PHASE_W-1:0]        out_phase
);
    localparam int XW = DATA_W + 2;
    localparam int ZW = PHASE_W + 1;

    function automatic logic signed [ZW-1:0] atan_lut(input int i);
        logic [63:0] t;
        int sh;
        sh = 32 - PHASE_W;
        case (i)
            0:  t = 64'h2000_0000;
            1:  t = 64'h12E4_051E;
            2:  t = 64'h09FB_385B;
            3:  t = 64'h0511_11D4;
            4:  t = 64'h028B_0D43;
            5:  t = 64'h0145_D7E1;
            6:  t = 64'h00A2_F61E;
            7:  t = 64'h0051_7C55;
            8:  t = 64'h0028_BE53;
            9:  t = 64'h0014_5F2F;
            10: t = 64'h000A_2F98;
            11: t = 64'h0005_17CC;
            12: t = 64'h0002_8BE6;
            13: t = 64'h0001_45F3;
            14: t = 64'h0000_A2FA;
            15: t = 64'h0000_517D;
            16: t = 64'h0000_28BE;
            17: t = 64'h0000_145F;
            18: t = 64'h0000_0A30;
            19: t = 64'h0000_0518;
            20: t = 64'h0000_028C;
            21: t = 64'h0000_0146;
            22: t = 64'h0000_00A3;
            23: t = 64'h0000_0051;
            24: t = 64'h0000_0029;
            25: t = 64'h0000_0014;
            26: t = 64'h0000_000A;
            27: t = 64'h0000_0005;
            28: t = 64'h0000_0003;
            29: t = 64'h0000_0001;
            30: t = 64'h0000_0001;
            default: t = 64'h0;
        endcase
        return ZW'((t + ((64'd1 << sh) >> 1)) >> sh);
    endfunction

    logic adv;
    logic neg;
    logic signed [XW-1:0] ix, iy, px, py;
    logic signed [ZW-1:0] pz;
    logic [1:0] pq;
    logic signed [XW-1:0] xs [0:STAGES];
    logic signed [XW-1:0] ys [0:STAGES];
    logic signed [ZW-1:0] zs [0:STAGES];
    logic [1:0] qs [0:STAGES];
    logic [STAGES:0] ms;
    logic [STAGES:0] vs;
    logic signed [XW-1:0] nx [0:STAGES-1];
    logic signed [XW-1:0] ny [0:STAGES-1];
    logic signed [ZW-1:0] nz [0:STAGES-1];
    logic [STAGES-1:0] dir;
    logic signed [XW-1:0] c, s, ox, oy;
    logic [1:0] q;
    logic m;
    logic [PHASE_W-1:0] op;

    assign adv = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        neg = in_mode & in_x[DATA_W-1];
        ix = XW'(in_x);
        iy = XW'(in_y);
        px = ~in_mode ? XW'(K_INIT) : neg ? -ix : ix;
        py = ~in_mode ? '0 : neg ? -iy : iy;
        pz = ~in_mode ? {3'b000, in_phase[PHASE_W-3:0]} : neg ? {2'b01, {(PHASE_W-1){1'b0}}} : '0;
        pq = in_mode ? 2'd0 : in_phase[PHASE_W-1 -: 2];
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stg
        localparam logic signed [ZW-1:0] A = atan_lut(i);
        assign dir[i] = ms[i] ? ys[i][XW-1] : ~zs[i][ZW-1];
        assign nx[i] = dir[i] ? xs[i] - (ys[i] >>> i) : xs[i] + (ys[i] >>> i);
        assign ny[i] = dir[i] ? ys[i] + (xs[i] >>> i) : ys[i] - (xs[i] >>> i);
        assign nz[i] = dir[i] ? zs[i] - A : zs[i] + A;
    end

    always_comb begin
        c = xs[STAGES];
        s = ys[STAGES];
        q = qs[STAGES];
        m = ms[STAGES];
        ox = m ? c : q == 2'd0 ? c : q == 2'd1 ? -s : q == 2'd2 ? -c : s;
        oy = m ? s : q == 2'd0 ? s : q == 2'd1 ? c : q == 2'd2 ? -s : -c;
        op = m ? zs[STAGES][PHASE_W-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vs <= '0;
            out_valid <= 1'b0;
            out_mode <= 1'b0;
            out_x <= '0;
            out_y <= '0;
            out_phase <= '0;
        end else if (adv) begin
            vs <= {vs[STAGES-1:0], in_valid};
            ms <= {ms[STAGES-1:0], in_mode};
            xs[0] <= px;
            ys[0] <= py;
            zs[0] <= pz;
            qs[0] <= pq;
            for (int k = 0; k < STAGES; k++) begin
                xs[k+1] <= nx[k];
                ys[k+1] <= ny[k];
                zs[k+1] <= nz[k];
                qs[k+1] <= qs[k];
            end
            out_valid <= vs[STAGES];
            out_mode <= m;
            out_x <= ox;
            out_y <= oy;
            out_phase <= op;
        end
    end
endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: directed and randomized checks of cordic_pipe against a floating-point trig model
module tb_cordic_pipe;
    localparam real PI = 3.14159265358979;
    localparam real GAIN = 1.64676;

    typedef struct {
        bit  m;
        real x;
        real y;
        real p;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic in_mode = 1'b0;
    logic [15:0] in_phase = '0;
    logic signed [15:0] in_x = '0;
    logic signed [15:0] in_y = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic out_mode;
    logic signed [17:0] out_x;
    logic signed [17:0] out_y;
    logic [15:0] out_phase;

    int n_chk = 0;
    int n_pass = 0;
    exp_t exp_q [$];
    bit held = 0;
    logic [53:0] saved;
    bit done = 0;

    cordic_pipe #(.DATA_W(16), .PHASE_W(16), .STAGES(14), .K_INIT(9949)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_phase(in_phase), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_x(out_x), .out_y(out_y), .out_phase(out_phase)
    );

    always #5 clk = ~clk;

    task automatic chk_int(input string tag, input longint got, input longint exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic chk_tol(input string tag, input real got, input real exp, input real tol);
        n_chk++;
        assert ((got - exp) <= tol && (exp - got) <= tol) n_pass++;
        else $error("FAIL %s got=%0.2f exp=%0.2f tol=%0.1f", tag, got, exp, tol);
    endtask

    task automatic chk_ph(input string tag, input real got, input real exp, input real tol);
        real d;
        d = got - exp;
        if (d > 32768.0) d = d - 65536.0;
        if (d < -32768.0) d = d + 65536.0;
        n_chk++;
        assert (d <= tol && -d <= tol) n_pass++;
        else $error("FAIL %s got=%0.2f exp=%0.2f tol=%0.1f", tag, got, exp, tol);
    endtask

    function automatic exp_t model(input bit m, input int ph, input int x, input int y);
        exp_t e;
        real a;
        e.m = m;
        if (!m) begin
            a = 2.0 * PI * ph / 65536.0;
            e.x = 16384.0 * $cos(a);
            e.y = 16384.0 * $sin(a);
            e.p = 0.0;
        end else begin
            e.x = GAIN * $sqrt(real'(x) * x + real'(y) * y);
            e.y = 0.0;
            a = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
            e.p = a < 0.0 ? a + 65536.0 : a;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            held = 0;
        end else begin
            if (held)
                chk_int("stall_hold", {out_valid, out_mode, out_x, out_y, out_phase}, saved);
            if (out_valid && out_ready) begin
                chk_int("out_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk_int("s_mode", out_mode, e.m);
                    chk_tol("s_x", out_x, e.x, 8.0);
                    chk_tol("s_y", out_y, e.y, 8.0);
                    chk_ph("s_phase", out_phase, e.p, e.m ? 6.0 : 0.0);
                end
            end
            held = out_valid && !out_ready;
            saved = {out_valid, out_mode, out_x, out_y, out_phase};
            if (in_valid && in_ready)
                exp_q.push_back(model(in_mode, int'(in_phase), int'(in_x), int'(in_y)));
        end
    end

    task automatic run_one(input string tag, input bit m, input int ph, input int x, input int y,
                           input real ex, input real tx, input real ey, input real ty,
                           input real ep, input real tp);
        int cyc;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode = m;
        in_phase = ph[15:0];
        in_x = x[15:0];
        in_y = y[15:0];
        cyc = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc++;
        end while (!out_valid && cyc < 40);
        chk_int({tag, "_latency"}, cyc, 16);
        chk_tol({tag, "_x"}, out_x, ex, tx);
        chk_tol({tag, "_y"}, out_y, ey, ty);
        chk_ph({tag, "_phase"}, out_phase, ep, tp);
    endtask

    task automatic rand_fields();
        int vx, vy;
        in_mode = 1'($urandom_range(1));
        in_phase = 16'($urandom_range(65535));
        do begin
            vx = int'($urandom_range(65535)) - 32768;
            vy = int'($urandom_range(65535)) - 32768;
        end while (vx * vx + vy * vy < 64000000);
        in_x = vx[15:0];
        in_y = vy[15:0];
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_int("rst_out_valid", out_valid, 0);
        chk_int("rst_in_ready", in_ready, 1);
        chk_int("rst_out_x", out_x, 0);
        chk_int("rst_out_y", out_y, 0);
        chk_int("rst_out_phase", out_phase, 0);
        chk_int("rst_out_mode", out_mode, 0);

        run_one("rot0000", 0, 'h0000, 0, 0, 16384.0, 4.0, 0.0, 4.0, 0.0, 0.0);
        run_one("rot2000", 0, 'h2000, 0, 0, 11585.0, 4.0, 11585.0, 4.0, 0.0, 0.0);
        run_one("rot4000", 0, 'h4000, 0, 0, 0.0, 4.0, 16384.0, 4.0, 0.0, 0.0);
        run_one("rot8000", 0, 'h8000, 0, 0, -16384.0, 4.0, 0.0, 4.0, 0.0, 0.0);
        run_one("rotC000", 0, 'hC000, 0, 0, 0.0, 4.0, -16384.0, 4.0, 0.0, 0.0);
        run_one("rotFFFF", 0, 'hFFFF, 0, 0, 16384.0, 4.0, -1.57, 4.0, 0.0, 0.0);
        run_one("vec_px", 1, 0, 10000, 0, 16468.0, 4.0, 0.0, 8.0, 0.0, 4.0);
        run_one("vec_py", 1, 0, 0, 10000, 16468.0, 8.0, 0.0, 8.0, 16384.0, 2.0);
        run_one("vec_nx", 1, 0, -10000, 0, 16468.0, 8.0, 0.0, 8.0, 32768.0, 2.0);
        run_one("vec_nn", 1, 0, -10000, -10000, 23289.0, 8.0, 0.0, 8.0, 40960.0, 2.0);
        run_one("vec_min", 1, 0, -32768, -32768, 76313.0, 8.0, 0.0, 8.0, 40960.0, 4.0);

        fork
            begin
                int k;
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk); #1;
                    if ($urandom_range(3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    in_valid = 1'b1;
                    rand_fields();
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (!in_ready && k < 100);
                    chk_int("accept_bound", in_ready, 1);
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
                k = 0;
                while (exp_q.size() != 0 && k < 3000) begin
                    @(posedge clk);
                    k++;
                end
                chk_int("drain", exp_q.size(), 0);
                done = 1;
            end
            begin
                int burst = 0;
                while (!done) begin
                    @(posedge clk); #1;
                    if (burst > 0) begin
                        out_ready = 1'b0;
                        burst--;
                    end else if ($urandom_range(7) == 0) begin
                        out_ready = 1'b0;
                        burst = 4;
                    end else begin
                        out_ready = 1'($urandom_range(1));
                    end
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;

        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            rand_fields();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_int("flush_out_valid", out_valid, 0);
        chk_int("flush_in_ready", in_ready, 1);
        run_one("post_flush", 0, 'h4000, 0, 0, 0.0, 4.0, 16384.0, 4.0, 0.0, 0.0);
        repeat (30) @(posedge clk);
        chk_int("flush_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
